// File: rtl/mac_window_sequencer.sv
// Serialises 3x3 fp32 pixel windows into per-tap beats paired with a coefficient bank,
// limits in-flight windows with a credit counter and flags frame drain completion.
module mac_window_sequencer #(
    parameter int unsigned TAPS            = 9,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_window_valid,
    output logic                     in_window_ready,
    input  logic [TAPS*DATA_W-1:0]   in_window,
    input  logic                     in_window_last,
    input  logic                     cfg_coeff_we,
    input  logic [3:0]               cfg_coeff_addr,
    input  logic [DATA_W-1:0]        cfg_coeff_data,
    output logic                     ou_cfg_busy,
    output logic                     ou_data_valid,
    input  logic                     in_data_ready,
    output logic [DATA_W-1:0]        ou_grayscale_fp,
    output logic [DATA_W-1:0]        ou_kernel_coeff,
    output logic                     ou_data_last,
    output logic                     ou_last_pixel,
    input  logic                     in_result_last_fire,
    output logic                     ou_frame_done,
    output logic                     ou_credit_err
);

    localparam int unsigned      TAP_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

    state_e              state_q;
    logic [TAP_W-1:0]    tap_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                last_q;
    logic                done_q;
    logic                err_q;
    logic [DATA_W-1:0]   win_q   [TAPS];
    logic [DATA_W-1:0]   coeff_q [TAPS];

    logic streaming;
    logic beat_fire;
    logic final_beat;
    logic coeff_wr;

    always_comb begin
        streaming  = (state_q == StStream);
        beat_fire  = streaming && in_data_ready;
        final_beat = beat_fire && (tap_q == TAP_LAST);
        coeff_wr   = cfg_coeff_we && (state_q == StIdle) && (32'(cfg_coeff_addr) < TAPS);
        cnt_d      = cnt_q;
        if (final_beat && !in_result_last_fire) begin
            cnt_d = cnt_q + 1'b1;
        end else if (in_result_last_fire && !final_beat && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tap_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                win_q[k]   <= '0;
                coeff_q[k] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            cnt_q  <= cnt_d;
            if (in_result_last_fire && !final_beat && (cnt_q == '0)) begin
                err_q <= 1'b1;
            end
            if (coeff_wr) begin
                coeff_q[TAP_W'(cfg_coeff_addr)] <= cfg_coeff_data;
            end
            unique case (state_q)
                StIdle: begin
                    if (in_window_valid && in_window_ready) begin
                        for (int k = 0; k < TAPS; k++) begin
                            win_q[k] <= in_window[k*DATA_W +: DATA_W];
                        end
                        last_q  <= in_window_last;
                        tap_q   <= '0;
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (beat_fire) begin
                        if (tap_q == TAP_LAST) begin
                            tap_q   <= '0;
                            state_q <= last_q ? StDrain : StIdle;
                        end else begin
                            tap_q <= tap_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    // Hold DRAIN through the pulse so no window sneaks in before frame_done.
                    if (done_q) begin
                        state_q <= StIdle;
                    end else if (cnt_d == '0) begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_window_ready = (state_q == StIdle) && (cnt_q < CNT_MAX);
    assign ou_cfg_busy     = (state_q != StIdle);
    assign ou_data_valid   = streaming;
    assign ou_grayscale_fp = streaming ? win_q[tap_q] : '0;
    assign ou_kernel_coeff = streaming ? coeff_q[tap_q] : '0;
    assign ou_data_last    = streaming && (tap_q == TAP_LAST);
    assign ou_last_pixel   = streaming && last_q;
    assign ou_frame_done   = done_q;
    assign ou_credit_err   = err_q;

endmodule
